// File: rtl/writeback_controller_if.sv
// Handshake and register-file write bundle for writeback_controller.
// The bypass signals exist only when WB_BYPASS_EN is defined.
interface writeback_controller_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  start;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       alu_result;
  logic [XLEN-1:0]       immediate;
  logic [XLEN-1:0]       pc;
  logic [1:0]            mem_addr_lo;
  logic [XLEN-1:0]       mem_data;
  logic                  mem_valid;
  logic                  busy;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]       rf_wdata;
  logic                  done;
  logic                  err;
`ifdef WB_BYPASS_EN
  logic                  byp_valid;
  logic [REG_ADDR_W-1:0] byp_addr;
  logic [XLEN-1:0]       byp_data;
`endif

  modport master (
    output start, opcode, funct3, rd, alu_result, immediate, pc,
           mem_addr_lo, mem_data, mem_valid,
`ifdef WB_BYPASS_EN
    input  byp_valid, byp_addr, byp_data,
`endif
    input  busy, rf_we, rf_waddr, rf_wdata, done, err
  );

  modport slave (
    input  start, opcode, funct3, rd, alu_result, immediate, pc,
           mem_addr_lo, mem_data, mem_valid,
`ifdef WB_BYPASS_EN
    output byp_valid, byp_addr, byp_data,
`endif
    output busy, rf_we, rf_waddr, rf_wdata, done, err
  );
endinterface

// File: rtl/writeback_controller.sv
// Register-update stage writeback FSM: selects the source per opcode and drives one
// registered register-file write port. Optional WB_BYPASS_EN adds a same-cycle forward port.
module writeback_controller #(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   reset,
  writeback_controller_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_WRITE    = 2'd2,
    S_FINISH   = 2'd3
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [7:0] CNT_LAST   = 8'(MEM_TIMEOUT - 1);
  localparam logic [XLEN-1:0] LINK_INC = XLEN'(4);

  state_t                r_state;
  logic [7:0]            r_cnt;
  logic [6:0]            r_opcode;
  logic [2:0]            r_funct3;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [1:0]            r_addr_lo;
  logic                  r_busy;
  logic                  r_rf_we;
  logic [REG_ADDR_W-1:0] r_rf_waddr;
  logic [XLEN-1:0]       r_rf_wdata;
  logic                  r_done;
  logic                  r_err;
  logic [XLEN-1:0]       w_load_data;

  function automatic logic [XLEN-1:0] f_extract(input logic [2:0]      f3,
                                                input logic [1:0]      off,
                                                input logic [XLEN-1:0] data);
    logic [7:0]  v_b;
    logic [15:0] v_h;
    logic [31:0] v_w;
    v_b = data[{off, 3'b000} +: 8];
    v_h = data[{off[1], 4'b0000} +: 16];
    v_w = data[31:0];
    case (f3)
      3'b000:  f_extract = XLEN'($signed(v_b));
      3'b100:  f_extract = XLEN'(v_b);
      3'b001:  f_extract = XLEN'($signed(v_h));
      3'b101:  f_extract = XLEN'(v_h);
      default: f_extract = XLEN'($signed(v_w));
    endcase
  endfunction

  // Load data is extracted from the live bus using the captured width and offset.
  always_comb begin
    w_load_data = f_extract(r_funct3, r_addr_lo, bus.mem_data);
  end

  // Single FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_opcode   <= 7'd0;
      r_funct3   <= 3'd0;
      r_rd       <= '0;
      r_addr_lo  <= 2'd0;
      r_busy     <= 1'b0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt   <= 8'd0;
          r_rf_we <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          if (bus.start) begin
            r_opcode  <= bus.opcode;
            r_funct3  <= bus.funct3;
            r_rd      <= bus.rd;
            r_addr_lo <= bus.mem_addr_lo;
            r_busy    <= 1'b1;
            case (bus.opcode)
              OPC_LOAD: begin
                r_state <= S_WAIT_MEM;
              end
              OPC_OP, OPC_OP_IMM, OPC_AUIPC: begin
                r_state    <= S_WRITE;
                r_rf_we    <= (bus.rd != {REG_ADDR_W{1'b0}});
                r_rf_waddr <= bus.rd;
                r_rf_wdata <= bus.alu_result;
                r_done     <= 1'b1;
              end
              OPC_LUI: begin
                r_state    <= S_WRITE;
                r_rf_we    <= (bus.rd != {REG_ADDR_W{1'b0}});
                r_rf_waddr <= bus.rd;
                r_rf_wdata <= bus.immediate;
                r_done     <= 1'b1;
              end
              OPC_JAL, OPC_JALR: begin
                r_state    <= S_WRITE;
                r_rf_we    <= (bus.rd != {REG_ADDR_W{1'b0}});
                r_rf_waddr <= bus.rd;
                r_rf_wdata <= bus.pc + LINK_INC;
                r_done     <= 1'b1;
              end
              default: begin
                r_state <= S_FINISH;
                r_done  <= 1'b1;
              end
            endcase
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_WAIT_MEM: begin
          // mem_valid is tested first so it wins over a coincident timeout.
          if (bus.mem_valid) begin
            r_state    <= S_WRITE;
            r_cnt      <= 8'd0;
            r_rf_we    <= (r_rd != {REG_ADDR_W{1'b0}});
            r_rf_waddr <= r_rd;
            r_rf_wdata <= w_load_data;
            r_done     <= 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_FINISH;
            r_cnt   <= 8'd0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WRITE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_rf_we <= 1'b0;
          r_done  <= 1'b0;
        end
        S_FINISH: begin
          // After a timeout, err takes one FINISH cycle and done the next.
          if (r_err) begin
            r_err  <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_rf_we <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.rf_we    = r_rf_we;
  assign bus.rf_waddr = r_rf_waddr;
  assign bus.rf_wdata = r_rf_wdata;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
`ifdef WB_BYPASS_EN
  assign bus.byp_valid = r_rf_we;
  assign bus.byp_addr  = r_rf_waddr;
  assign bus.byp_data  = r_rf_wdata;
`endif
endmodule

// File: tb/tb_writeback_controller.sv
// Directed plus randomized bench for writeback_controller against a cycle-schedule reference model.
module tb_writeback_controller;
  localparam int MEM_TO = 15;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [4:0]  held_addr;
  logic [31:0] held_data;

  writeback_controller_if #(.XLEN(32), .REG_ADDR_W(5)) wb_if ();

  writeback_controller #(.XLEN(32), .REG_ADDR_W(5), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (wb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input logic busy_e, input logic we_e, input logic done_e, input logic err_e);
    chk("busy", 32'(wb_if.busy), 32'(busy_e));
    chk("rf_we", 32'(wb_if.rf_we), 32'(we_e));
    chk("done", 32'(wb_if.done), 32'(done_e));
    chk("err", 32'(wb_if.err), 32'(err_e));
    chk("rf_waddr", 32'(wb_if.rf_waddr), 32'(held_addr));
    chk("rf_wdata", wb_if.rf_wdata, held_data);
`ifdef WB_BYPASS_EN
    chk("byp_valid", 32'(wb_if.byp_valid), 32'(we_e));
    chk("byp_data", wb_if.byp_data, held_data);
`endif
  endtask

  function automatic bit is_known(input logic [6:0] opc);
    return opc inside {7'b0000011, 7'b0010011, 7'b0110011, 7'b0010111,
                       7'b0110111, 7'b1101111, 7'b1100111};
  endfunction

  // Reference value from the instruction-level rules, using plain integer arithmetic.
  function automatic logic [31:0] ref_value(input logic [6:0] opc, input logic [2:0] f3,
                                            input logic [1:0] off, input logic [31:0] alu,
                                            input logic [31:0] imm, input logic [31:0] pcv,
                                            input logic [31:0] mem);
    longint b, h, s;
    b = longint'((mem >> (8 * int'(off))) & 32'hFF);
    h = longint'((mem >> (16 * (int'(off) / 2))) & 32'hFFFF);
    case (opc)
      7'b0000011: begin
        case (f3)
          3'd0:    s = (b >= 128) ? b - 256 : b;
          3'd4:    s = b;
          3'd1:    s = (h >= 32768) ? h - 65536 : h;
          3'd5:    s = h;
          default: s = longint'(mem);
        endcase
      end
      7'b0010011, 7'b0110011, 7'b0010111: s = longint'(alu);
      7'b0110111:                         s = longint'(imm);
      7'b1101111, 7'b1100111:             s = longint'(pcv) + 64'sd4;
      default:                            s = 64'sd0;
    endcase
    return s[31:0];
  endfunction

  // One instruction: start in cycle k=0, then check every cycle up to and including busy falling.
  task automatic run_txn(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd_i,
                         input logic [31:0] alu, input logic [31:0] imm, input logic [31:0] pcv,
                         input logic [31:0] mem, input logic [1:0] off, input int delay,
                         input bit noise);
    bit          ld;
    bit          tmo;
    bit          wr;
    int          wk;
    logic [31:0] val;
    ld  = (opc == 7'b0000011);
    tmo = ld && (delay >= MEM_TO);
    wr  = is_known(opc) && !tmo;
    wk  = !ld ? 1 : (tmo ? MEM_TO + 2 : delay + 2);
    val = ref_value(opc, f3, off, alu, imm, pcv, mem);
    wb_if.start       = 1'b1;
    wb_if.opcode      = opc;
    wb_if.funct3      = f3;
    wb_if.rd          = rd_i;
    wb_if.alu_result  = alu;
    wb_if.immediate   = imm;
    wb_if.pc          = pcv;
    wb_if.mem_addr_lo = off;
    wb_if.mem_data    = mem;
    wb_if.mem_valid   = 1'b0;
    for (int k = 1; k <= wk + 1; k++) begin
      step();
      if (k == wk && wr) begin
        held_addr = rd_i;
        held_data = val;
      end
      chk_all(k <= wk, (k == wk) && wr && (rd_i != 5'd0), k == wk, tmo && (k == MEM_TO + 1));
      wb_if.start = noise && (k == 1);
      if (wb_if.start) begin
        wb_if.opcode     = 7'b0110011;
        wb_if.rd         = ~rd_i;
        wb_if.alu_result = ~alu;
      end
      wb_if.mem_valid = ld && (k == delay + 1);
    end
    wb_if.start     = 1'b0;
    wb_if.mem_valid = 1'b0;
  endtask

  logic [6:0] opc_tab [8];

  initial begin
    n_vec = 0;
    n_err = 0;
    held_addr = 5'd0;
    held_data = 32'd0;
    opc_tab = '{7'b0000011, 7'b0010011, 7'b0110011, 7'b0010111,
                7'b0110111, 7'b1101111, 7'b1100111, 7'b1110011};
    reset = 1'b1;
    wb_if.start = 1'b0;
    wb_if.opcode = 7'd0;
    wb_if.funct3 = 3'd0;
    wb_if.rd = 5'd0;
    wb_if.alu_result = 32'd0;
    wb_if.immediate = 32'd0;
    wb_if.pc = 32'd0;
    wb_if.mem_addr_lo = 2'd0;
    wb_if.mem_data = 32'd0;
    wb_if.mem_valid = 1'b0;
    step();
    step();
    chk_all(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) step();

    // OP-IMM rd=5, then JAL wrap, then LB/LBU byte 2 with mem_valid three cycles after start.
    run_txn(7'b0010011, 3'd0, 5'd5, 32'h0000_1234, 32'd0, 32'd0, 32'd0, 2'd0, 0, 1'b0);
    chk("opimm_wdata", wb_if.rf_wdata, 32'h0000_1234);
    run_txn(7'b1101111, 3'd0, 5'd1, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd0, 2'd0, 0, 1'b0);
    chk("jal_wrap", wb_if.rf_wdata, 32'h0000_0000);
    run_txn(7'b0000011, 3'd0, 5'd3, 32'd0, 32'd0, 32'd0, 32'h0080_0000, 2'd2, 2, 1'b0);
    chk("lb_sext", wb_if.rf_wdata, 32'hFFFF_FF80);
    run_txn(7'b0000011, 3'd4, 5'd3, 32'd0, 32'd0, 32'd0, 32'h0080_0000, 2'd2, 2, 1'b0);
    chk("lbu_zext", wb_if.rf_wdata, 32'h0000_0080);
    // Timeout, then mem_valid exactly on the timeout cycle, then LUI to x0 with a start while busy.
    run_txn(7'b0000011, 3'd2, 5'd9, 32'd0, 32'd0, 32'd0, 32'h1111_2222, 2'd0, 40, 1'b0);
    run_txn(7'b0000011, 3'd2, 5'd9, 32'd0, 32'd0, 32'd0, 32'h1111_2222, 2'd0, MEM_TO - 1, 1'b1);
    run_txn(7'b0110111, 3'd0, 5'd0, 32'd0, 32'hABCD_E000, 32'd0, 32'd0, 2'd0, 0, 1'b1);
    chk("lui_x0_addr", 32'(wb_if.rf_waddr), 32'd0);
    run_txn(7'b0000011, 3'd1, 5'd12, 32'd0, 32'd0, 32'd0, 32'h8001_7FFF, 2'd2, 5, 1'b1);

    for (int i = 0; i < 40; i++) begin
      run_txn(opc_tab[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), 5'($urandom),
              $urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
              int'($urandom_range(0, 17)), 1'($urandom));
    end

    // Asynchronous reset in the middle of WAIT_MEM, then a stale mem_valid.
    wb_if.start = 1'b1;
    wb_if.opcode = 7'b0000011;
    wb_if.rd = 5'd17;
    step();
    wb_if.start = 1'b0;
    step();
    step();
    chk("busy_before_reset", 32'(wb_if.busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    held_addr = 5'd0;
    held_data = 32'd0;
    chk_all(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    wb_if.mem_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_all(1'b0, 1'b0, 1'b0, 1'b0);
    end
    wb_if.mem_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
